// File: rtl/binary_bbox_detect_pkg.sv
// Shared definitions for the binary bounding-box detector:
// FSM state encoding and accumulator start-of-frame fill values.
package binary_bbox_detect_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACCUM      = 2'd1,
        LATCH      = 2'd2
    } bbox_state_e;

    // Min starts all-ones and max all-zeros so the first white pixel wins both compares.
    localparam logic ACC_MIN_FILL = 1'b1;
    localparam logic ACC_MAX_FILL = 1'b0;
    localparam logic ACC_CNT_FILL = 1'b0;

endpackage

// File: rtl/binary_bbox_detect_accum.sv
// Min/max extent and saturating population accumulator for white pixels,
// with a synchronous re-initialise control used at frame boundaries.
module bbox_accum
    import binary_bbox_detect_pkg::*;
#(
    parameter int CNT_W = 12
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_init,
    input  logic               i_en,
    input  logic [CNT_W-1:0]   i_x,
    input  logic [CNT_W-1:0]   i_y,
    output logic [CNT_W-1:0]   o_min_x,
    output logic [CNT_W-1:0]   o_max_x,
    output logic [CNT_W-1:0]   o_min_y,
    output logic [CNT_W-1:0]   o_max_y,
    output logic [2*CNT_W-1:0] o_cnt
);

    localparam logic [2*CNT_W-1:0] CNT_ONE = {{(2*CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2*CNT_W-1:0] CNT_SAT = {(2*CNT_W){1'b1}};

    logic [CNT_W-1:0]   r_min_x;
    logic [CNT_W-1:0]   r_max_x;
    logic [CNT_W-1:0]   r_min_y;
    logic [CNT_W-1:0]   r_max_y;
    logic [2*CNT_W-1:0] r_cnt;

    // Running extent and saturating count of accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_x <= {CNT_W{1'b0}};
            r_max_x <= {CNT_W{1'b0}};
            r_min_y <= {CNT_W{1'b0}};
            r_max_y <= {CNT_W{1'b0}};
            r_cnt   <= {(2*CNT_W){1'b0}};
        end else if (i_init) begin
            r_min_x <= {CNT_W{ACC_MIN_FILL}};
            r_max_x <= {CNT_W{ACC_MAX_FILL}};
            r_min_y <= {CNT_W{ACC_MIN_FILL}};
            r_max_y <= {CNT_W{ACC_MAX_FILL}};
            r_cnt   <= {(2*CNT_W){ACC_CNT_FILL}};
        end else if (i_en) begin
            r_min_x <= (i_x < r_min_x) ? i_x : r_min_x;
            r_max_x <= (i_x > r_max_x) ? i_x : r_max_x;
            r_min_y <= (i_y < r_min_y) ? i_y : r_min_y;
            r_max_y <= (i_y > r_max_y) ? i_y : r_max_y;
            r_cnt   <= (r_cnt == CNT_SAT) ? r_cnt : (r_cnt + CNT_ONE);
        end
    end

    assign o_min_x = r_min_x;
    assign o_max_x = r_max_x;
    assign o_min_y = r_min_y;
    assign o_max_y = r_max_y;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/binary_bbox_detect.sv
// Bounding box of white pixels in a binarized video frame, reported once per
// frame and drawn as a coloured rectangle over the display stream.
module binary_bbox_detect
    import binary_bbox_detect_pkg::*;
#(
    parameter int                        IMG_WIDTH_DATA = 24,
    parameter int                        CNT_W          = 12,
    parameter int                        MIN_PIXELS     = 16,
    parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR      = 24'hFF0000
)(
    input  logic                      pixel_clk,
    input  logic                      reset_n,
    input  logic [IMG_WIDTH_DATA-1:0] i_binary,
    input  logic [IMG_WIDTH_DATA-1:0] i_rgb,
    input  logic                      i_h_sync,
    input  logic                      i_v_sync,
    input  logic                      i_de,
    output logic [IMG_WIDTH_DATA-1:0] o_rgb,
    output logic                      o_h_sync,
    output logic                      o_v_sync,
    output logic                      o_de,
    output logic [CNT_W-1:0]          box_x_min,
    output logic [CNT_W-1:0]          box_x_max,
    output logic [CNT_W-1:0]          box_y_min,
    output logic [CNT_W-1:0]          box_y_max,
    output logic [2*CNT_W-1:0]        box_pix_cnt,
    output logic                      box_found,
    output logic                      box_valid
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2*CNT_W-1:0] MIN_PIX  = (2*CNT_W)'(MIN_PIXELS);

    bbox_state_e               r_state;
    logic                      r_de;
    logic                      r_hs;
    logic                      r_vs;
    logic [IMG_WIDTH_DATA-1:0] r_rgb;
    logic [CNT_W-1:0]          r_x_cnt;
    logic [CNT_W-1:0]          r_y_cnt;
    logic [CNT_W-1:0]          r_box_x_min;
    logic [CNT_W-1:0]          r_box_x_max;
    logic [CNT_W-1:0]          r_box_y_min;
    logic [CNT_W-1:0]          r_box_y_max;
    logic [2*CNT_W-1:0]        r_box_pix_cnt;
    logic                      r_box_found;
    logic                      r_box_valid;

    logic                      w_de_fall;
    logic                      w_vs_rise;
    logic                      w_white;
    logic                      w_unused_bin;
    logic                      w_acc_init;
    logic                      w_acc_en;
    logic                      w_enough;
    logic                      w_x_in;
    logic                      w_y_in;
    logic                      w_on_border;
    logic [CNT_W-1:0]          w_acc_min_x;
    logic [CNT_W-1:0]          w_acc_max_x;
    logic [CNT_W-1:0]          w_acc_min_y;
    logic [CNT_W-1:0]          w_acc_max_y;
    logic [2*CNT_W-1:0]        w_acc_cnt;

    // The delayed video registers double as the edge-detect history.
    assign w_de_fall    = r_de & ~i_de;
    assign w_vs_rise    = i_v_sync & ~r_vs;
    assign w_white      = i_binary[IMG_WIDTH_DATA-1];
    assign w_unused_bin = ^i_binary[IMG_WIDTH_DATA-2:0];

    // A pixel coincident with the closing vsync edge still sees ACCUM and is counted.
    assign w_acc_init = (r_state != ACCUM);
    assign w_acc_en   = (r_state == ACCUM) & i_de & w_white;
    assign w_enough   = (w_acc_cnt >= MIN_PIX);

    assign w_x_in      = (r_x_cnt >= r_box_x_min) && (r_x_cnt <= r_box_x_max);
    assign w_y_in      = (r_y_cnt >= r_box_y_min) && (r_y_cnt <= r_box_y_max);
    assign w_on_border = r_box_found && i_de &&
                         ((((r_x_cnt == r_box_x_min) || (r_x_cnt == r_box_x_max)) && w_y_in) ||
                          (((r_y_cnt == r_box_y_min) || (r_y_cnt == r_box_y_max)) && w_x_in));

    bbox_accum #(
        .CNT_W (CNT_W)
    ) u_accum (
        .clk     (pixel_clk),
        .rst_n   (reset_n),
        .i_init  (w_acc_init),
        .i_en    (w_acc_en),
        .i_x     (r_x_cnt),
        .i_y     (r_y_cnt),
        .o_min_x (w_acc_min_x),
        .o_max_x (w_acc_max_x),
        .o_min_y (w_acc_min_y),
        .o_max_y (w_acc_max_y),
        .o_cnt   (w_acc_cnt)
    );

    // Saturating pixel coordinates derived from the timing signals.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_cnt <= CNT_ZERO;
            r_y_cnt <= CNT_ZERO;
        end else begin
            if (w_de_fall) begin
                r_x_cnt <= CNT_ZERO;
            end else if (i_de && (r_x_cnt != CNT_MAX)) begin
                r_x_cnt <= r_x_cnt + CNT_ONE;
            end
            if (w_vs_rise) begin
                r_y_cnt <= CNT_ZERO;
            end else if (w_de_fall && (r_y_cnt != CNT_MAX)) begin
                r_y_cnt <= r_y_cnt + CNT_ONE;
            end
        end
    end

    // One-cycle video pipeline with the previous frame's box drawn on top.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_de  <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_rgb <= {IMG_WIDTH_DATA{1'b0}};
        end else begin
            r_de  <= i_de;
            r_hs  <= i_h_sync;
            r_vs  <= i_v_sync;
            r_rgb <= w_on_border ? BOX_COLOR : i_rgb;
        end
    end

    // Frame sequencing FSM; results are captured during the single LATCH cycle.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= WAIT_FRAME;
            r_box_x_min   <= CNT_ZERO;
            r_box_x_max   <= CNT_ZERO;
            r_box_y_min   <= CNT_ZERO;
            r_box_y_max   <= CNT_ZERO;
            r_box_pix_cnt <= {(2*CNT_W){1'b0}};
            r_box_found   <= 1'b0;
            r_box_valid   <= 1'b0;
        end else begin
            r_box_valid <= 1'b0;
            case (r_state)
                WAIT_FRAME: r_state <= w_vs_rise ? ACCUM : WAIT_FRAME;
                ACCUM:      r_state <= w_vs_rise ? LATCH : ACCUM;
                LATCH: begin
                    r_state       <= ACCUM;
                    r_box_valid   <= 1'b1;
                    r_box_pix_cnt <= w_acc_cnt;
                    r_box_found   <= w_enough;
                    r_box_x_min   <= w_enough ? w_acc_min_x : CNT_ZERO;
                    r_box_x_max   <= w_enough ? w_acc_max_x : CNT_ZERO;
                    r_box_y_min   <= w_enough ? w_acc_min_y : CNT_ZERO;
                    r_box_y_max   <= w_enough ? w_acc_max_y : CNT_ZERO;
                end
                default: r_state <= WAIT_FRAME;
            endcase
        end
    end

    assign o_rgb       = r_rgb;
    assign o_h_sync    = r_hs;
    assign o_v_sync    = r_vs;
    assign o_de        = r_de;
    assign box_x_min   = r_box_x_min;
    assign box_x_max   = r_box_x_max;
    assign box_y_min   = r_box_y_min;
    assign box_y_max   = r_box_y_max;
    assign box_pix_cnt = r_box_pix_cnt;
    assign box_found   = r_box_found;
    assign box_valid   = r_box_valid;

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Self-checking bench for binary_bbox_detect: directed frame table, reset and
// vsync-coincidence sequences, and random frames against a frame-level model.
module tb_binary_bbox_detect;

    localparam int          CW    = 4;
    localparam int          MINP  = 4;
    localparam int          XMAX  = 15;
    localparam int          CMAX  = 255;
    localparam logic [23:0] BOXC  = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;

    logic          pixel_clk = 1'b0;
    logic          reset_n;
    logic [23:0]   i_binary;
    logic [23:0]   i_rgb;
    logic          i_h_sync;
    logic          i_v_sync;
    logic          i_de;
    logic [23:0]   o_rgb;
    logic          o_h_sync;
    logic          o_v_sync;
    logic          o_de;
    logic [CW-1:0] box_x_min;
    logic [CW-1:0] box_x_max;
    logic [CW-1:0] box_y_min;
    logic [CW-1:0] box_y_max;
    logic [2*CW-1:0] box_pix_cnt;
    logic          box_found;
    logic          box_valid;

    binary_bbox_detect #(
        .IMG_WIDTH_DATA (24),
        .CNT_W          (CW),
        .MIN_PIXELS     (MINP),
        .BOX_COLOR      (BOXC)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .i_binary    (i_binary),
        .i_rgb       (i_rgb),
        .i_h_sync    (i_h_sync),
        .i_v_sync    (i_v_sync),
        .i_de        (i_de),
        .o_rgb       (o_rgb),
        .o_h_sync    (o_h_sync),
        .o_v_sync    (o_v_sync),
        .o_de        (o_de),
        .box_x_min   (box_x_min),
        .box_x_max   (box_x_max),
        .box_y_min   (box_y_min),
        .box_y_max   (box_y_max),
        .box_pix_cnt (box_pix_cnt),
        .box_found   (box_found),
        .box_valid   (box_valid)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_seen = 0;
    int exp_valid = 0;

    always @(negedge pixel_clk) begin
        if (box_valid) valid_seen = valid_seen + 1;
    end

    // Frame-level reference model: pixel grid plus latched expectations.
    logic img [0:19][0:19];
    bit   armed, prev_vs;
    int   acc_n, acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    int   m_xmin, m_xmax, m_ymin, m_ymax, m_cnt;
    bit   m_found;
    bit   pend_valid = 1'b0;
    logic [26:0] pend_exp;

    typedef struct {
        int          x0, x1, y0, y1;
        logic [24:0] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [24:0] model_pack();
        return {4'(m_xmin), 4'(m_xmax), 4'(m_ymin), 4'(m_ymax), 8'(m_cnt), m_found};
    endfunction

    function automatic logic [24:0] dut_pack();
        return {box_x_min, box_x_max, box_y_min, box_y_max, box_pix_cnt, box_found};
    endfunction

    task automatic acc_clear();
        acc_n = 0; acc_xmin = 9999; acc_xmax = -1; acc_ymin = 9999; acc_ymax = -1;
    endtask

    task automatic model_reset();
        armed = 1'b0; prev_vs = 1'b0; acc_clear();
        m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_cnt = 0; m_found = 1'b0;
    endtask

    task automatic close_frame();
        exp_valid = exp_valid + 1;
        m_cnt = (acc_n > CMAX) ? CMAX : acc_n;
        m_found = (acc_n >= MINP);
        if (m_found) begin
            m_xmin = acc_xmin; m_xmax = acc_xmax; m_ymin = acc_ymin; m_ymax = acc_ymax;
        end else begin
            m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
        end
    endtask

    // One pixel clock: check the previous cycle's video, drive, predict, accumulate.
    task automatic drive(input logic de, input logic hs, input logic vs, input logic white,
                         input logic [23:0] rgb, input int col, input int row);
        int x, y;
        bit on;
        @(negedge pixel_clk);
        if (pend_valid) check("video", {o_de, o_h_sync, o_v_sync, o_rgb}, pend_exp);
        i_de = de; i_h_sync = hs; i_v_sync = vs; i_rgb = rgb;
        i_binary = {white, 23'($urandom)};
        x = (col > XMAX) ? XMAX : col;
        y = (row > XMAX) ? XMAX : row;
        on = m_found && de &&
             ((((x == m_xmin) || (x == m_xmax)) && (y >= m_ymin) && (y <= m_ymax)) ||
              (((y == m_ymin) || (y == m_ymax)) && (x >= m_xmin) && (x <= m_xmax)));
        pend_exp = reset_n ? {de, hs, vs, (on ? BOXC : rgb)} : 27'd0;
        pend_valid = 1'b1;
        if (reset_n) begin
            if (armed && de && white) begin
                acc_n = acc_n + 1;
                if (x < acc_xmin) acc_xmin = x;
                if (x > acc_xmax) acc_xmax = x;
                if (y < acc_ymin) acc_ymin = y;
                if (y > acc_ymax) acc_ymax = y;
            end
            if (vs && !prev_vs) begin
                if (armed) close_frame();
                armed = 1'b1;
                acc_clear();
            end
            prev_vs = vs;
        end
    endtask

    task automatic send_rows(input int r0, input int r1, input int w, input bit rnd_rgb);
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < w; c++)
                drive(1'b1, 1'b0, 1'b0, img[r][c], rnd_rgb ? 24'($urandom) : GREEN, c, r);
            drive(1'b0, 1'b1, 1'b0, 1'b0, GREEN, 0, 0);
            drive(1'b0, 1'b1, 1'b0, 1'b0, GREEN, 0, 0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
        end
    endtask

    task automatic vsync();
        drive(1'b0, 1'b0, 1'b1, 1'b0, GREEN, 0, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, GREEN, 0, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
    endtask

    task automatic fill_rect(input int x0, input int x1, input int y0, input int y1);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                img[r][c] = (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1);
    endtask

    task automatic check_results(input string name);
        check({name, " box"}, dut_pack(), model_pack());
        check({name, " valid count"}, valid_seen, exp_valid);
    endtask

    initial begin
        vecs[0] = '{2, 4, 3, 5,  {4'd2, 4'd4, 4'd3, 4'd5, 8'd9,  1'b1}};
        vecs[1] = '{0, -1, 0, -1, {4'd0, 4'd0, 4'd0, 4'd0, 8'd0,  1'b0}};
        vecs[2] = '{1, 3, 6, 6,  {4'd0, 4'd0, 4'd0, 4'd0, 8'd3,  1'b0}};
        vecs[3] = '{6, 7, 0, 1,  {4'd6, 4'd7, 4'd0, 4'd1, 8'd4,  1'b1}};
        vecs[4] = '{0, 7, 0, 7,  {4'd0, 4'd7, 4'd0, 4'd7, 8'd64, 1'b1}};

        reset_n = 1'b0; i_de = 1'b0; i_h_sync = 1'b0; i_v_sync = 1'b0;
        i_rgb = 24'd0; i_binary = 24'd0;
        model_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
        check("reset state", {o_rgb, o_de, o_h_sync, o_v_sync, box_valid, dut_pack()}, 53'd0);
        @(posedge pixel_clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
        vsync();
        check_results("arming vsync");

        // Directed 8x8 frames; the second one sees the first frame's box overlaid.
        for (int v = 0; v < 5; v++) begin
            fill_rect(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1);
            send_rows(0, 7, 8, 1'b0);
            vsync();
            check($sformatf("table[%0d] expected", v), dut_pack(), vecs[v].exp);
            check_results($sformatf("table[%0d] model", v));
        end

        // Reset in the middle of a line discards the partial frame.
        fill_rect(1, 6, 1, 6);
        send_rows(0, 3, 8, 1'b0);
        drive(1'b1, 1'b0, 1'b0, img[4][0], GREEN, 0, 4);
        drive(1'b1, 1'b0, 1'b0, img[4][1], GREEN, 1, 4);
        @(posedge pixel_clk); #2 reset_n = 1'b0;
        #1 check("async reset", {o_rgb, o_de, o_h_sync, o_v_sync, box_valid, dut_pack()}, 53'd0);
        pend_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
        @(posedge pixel_clk); #1 reset_n = 1'b1;
        send_rows(4, 7, 8, 1'b0);
        vsync();
        check_results("post-reset arm");
        fill_rect(2, 4, 3, 5);
        send_rows(0, 7, 8, 1'b0);
        vsync();
        check("post-reset frame", dut_pack(), {4'd2, 4'd4, 4'd3, 4'd5, 8'd9, 1'b1});
        check_results("post-reset model");

        // Last white pixel of the frame lands on the vsync rising edge.
        fill_rect(4, 7, 7, 7);
        send_rows(0, 6, 8, 1'b0);
        for (int c = 0; c < 7; c++) drive(1'b1, 1'b0, 1'b0, img[7][c], GREEN, c, 7);
        drive(1'b1, 1'b0, 1'b1, 1'b1, GREEN, 7, 7);
        drive(1'b0, 1'b0, 1'b1, 1'b0, GREEN, 0, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
        check("vsync coincident", dut_pack(), {4'd4, 4'd7, 4'd7, 4'd7, 8'd4, 1'b1});
        check_results("vsync coincident model");
        vsync();
        check_results("realign frame");

        // Random frames, including one large enough to saturate coordinates and count.
        for (int f = 0; f < 10; f++) begin
            int w, h, dens, pick;
            w = (f == 0) ? 20 : $urandom_range(1, 20);
            h = (f == 0) ? 20 : $urandom_range(1, 20);
            pick = $urandom_range(0, 3);
            dens = (f == 0) ? 100 : (pick == 0) ? 0 : (pick == 1) ? 10 : (pick == 2) ? 50 : 100;
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 20; c++)
                    img[r][c] = ($urandom_range(0, 99) < dens);
            send_rows(0, h - 1, w, 1'b1);
            vsync();
            check_results($sformatf("random[%0d] %0dx%0d d%0d", f, w, h, dens));
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, GREEN, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
